dmem_lsu: RTL
=============

# dmem_lsu

Load/store unit that acts as the initiator toward the single-port data memory (`en`/`r_w`/`address`/`in`/`out`, one-cycle registered read, word-indexed). It accepts byte-addressed load/store requests from the pipeline and converts them to word indices. Sub-word stores become read-modify-write sequences, and load data is sign- or zero-extended. Misaligned or out-of-range requests return a fault without touching memory.

## Interface
- `DEPTH`, 2048: memory depth in 32-bit words; word index must be < DEPTH.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; a request is accepted on an edge where `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_signed` in 1: sign-extend a load (ignored for stores and word loads).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse; there is no backpressure.
- `resp_rdata` out 32: load result; 0 for stores and faults.
- `resp_fault` out 1: qualifies `resp_valid`.
- `mem_en`, `mem_r_w` out 1 each: memory enable, and 1 = write.
- `mem_address` out 32: word index, `{2'b0, addr[31:2]}`.
- `mem_in` out 32: write word.
- `mem_out` in 32: memory read data, valid the cycle after a read edge.

## Operation
- The accepted request (addr, size, signed, we, wdata) is registered on acceptance.
- Fault check at acceptance:
  - size 11;
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - word index ≥ DEPTH.
  - A faulting request goes IDLE→RESP with fault=1 and no memory access.
- Lanes are little-endian:
  - byte k = bits [8k+7:8k], with k = addr[1:0];
  - half at offset 0 = [15:0], at offset 2 = [31:16].
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR, RESP.
  - IDLE: load or sub-word store → RD_ISSUE; word store → WR; fault → RESP.
  - RD_ISSUE: `mem_en`=1, `mem_r_w`=0 → RD_WAIT.
  - RD_WAIT: `mem_en`=0. Capture `mem_out`.
    - Load: extract and extend into `resp_rdata` → RESP.
    - Sub-word store: merge store lanes into the captured word → WR.
  - WR: `mem_en`=1, `mem_r_w`=1, `mem_in` = merged word (or wdata for a word store) → RESP.
  - RESP: `resp_valid`=1 for exactly one cycle → IDLE.
- `mem_en`, `mem_r_w`, `mem_address` and `mem_in` are decoded from state and registered request only, never from `req_*` directly.
- `mem_address` and `mem_in` are 0 whenever `mem_en`=0.
- Exactly one memory write per store; loads never write.

## Timing
- Acceptance edge = cycle 0. `resp_valid` is high in:
  - cycle 3 for a load;
  - cycle 2 for a word store;
  - cycle 4 for a sub-word store;
  - cycle 1 for a fault.
- Minimum spacing between acceptances:
  - load: 4 cycles;
  - word store: 3 cycles;
  - sub-word store: 5 cycles;
  - fault: 2 cycles.
- `req_ready` is low from cycle 1 through the RESP cycle. A request held high across RESP is accepted on the edge ending the IDLE cycle that follows.
- Reset values: state IDLE, `req_ready` 1, `mem_en` 0, `mem_r_w` 0, `mem_address` 0, `mem_in` 0, `resp_valid` 0, `resp_rdata` 0, `resp_fault` 0.
- Reset asserted mid-operation:
  - abort immediately;
  - no pending write is issued after reset releases;
  - no response is produced for the aborted request.
- `resp_rdata` and `resp_fault` hold their last values outside RESP. Consumers sample them only with `resp_valid`.

## Structure
- Package `lsu_pkg` holds:
  - `size_t` enum (BYTE, HALF, WORD);
  - `lsu_state_t` enum;
  - `WORD_BYTES` = 4.
- Sub-module `lsu_align` is purely combinational:
  - `extract(word, offset, size, signed)` → 32-bit result;
  - `merge(word, wdata, offset, size)` → 32-bit write word.
- `dmem_lsu` holds the FSM, the request registers, and the captured read word.

## Test plan
- Word store 0xDEADBEEF at 0x10, then word load at 0x10 → one write to index 4. Load `resp_rdata`=0xDEADBEEF, `resp_valid` in cycle 3.
- Memory word 4 = 0x11223344; byte store 0xAB at 0x13 → read index 4, then write 0xAB223344. Signed byte load at 0x13 → 0xFFFFFFAB; unsigned → 0x000000AB.
- Word 4 = 0x80017FFF: signed half load at 0x12 → 0xFFFF8001; unsigned half load at 0x10 → 0x00007FFF.
- Word load at 0x6, half load at 0x11, and word load at 0x2000 → each gives `resp_fault`=1 in cycle 1, `resp_rdata`=0, `mem_en` never high.
- `req_valid` held high with three queued loads → `req_ready` low during each operation, acceptances 4 cycles apart, responses in order.
- `rst_n` pulsed low during RD_WAIT of a byte store → all outputs at reset values immediately, no write cycle after release, no `resp_valid`.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
package lsu_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } size_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR,
    RESP
  } lsu_state_t;

  // Misalignment, illegal size, or a word index past the end of memory.
  function automatic logic req_fault(input logic [1:0]  size,
                                     input logic [31:0] addr,
                                     input logic [31:0] depth);
    logic f;
    f = 1'b0;
    case (size)
      2'b01:   f = addr[0];
      2'b10:   f = |addr[1:0];
      2'b11:   f = 1'b1;
      default: f = 1'b0;
    endcase
    if ({2'b00, addr[31:2]} >= depth) f = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Pipeline-side request/response bus and memory-side bus of the LSU.
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

interface dmem_mem_if;
  logic        mem_en;
  logic        mem_r_w;
  logic [31:0] mem_address;
  logic [31:0] mem_in;
  logic [31:0] mem_out;

  modport master (
    output mem_en, mem_r_w, mem_address, mem_in,
    input  mem_out
  );

  modport slave (
    input  mem_en, mem_r_w, mem_address, mem_in,
    output mem_out
  );
endinterface

// File: rtl/dmem_lsu_align.sv
// Little-endian lane extraction with sign/zero extension, and store-lane merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  size_t       size,
  input  logic        sign_ext,
  output logic [31:0] rdata,
  output logic [31:0] wword
);

  logic [4:0]  shamt;
  logic [31:0] rd_sh;
  logic [31:0] wr_sh;

  always_comb begin
    shamt = {offset, 3'b000};
    rd_sh = word >> shamt;
    wr_sh = wdata << shamt;

    rdata = rd_sh;
    case (size)
      BYTE:    rdata = {{24{sign_ext & rd_sh[7]}}, rd_sh[7:0]};
      HALF:    rdata = {{16{sign_ext & rd_sh[15]}}, rd_sh[15:0]};
      default: rdata = rd_sh;
    endcase
  end

  always_comb begin
    logic sel;
    wword = word;
    for (int unsigned k = 0; k < WORD_BYTES; k++) begin
      sel = 1'b1;
      case (size)
        BYTE:    sel = (k[1:0] == offset);
        HALF:    sel = (k[1] == offset[1]);
        default: sel = 1'b1;
      endcase
      if (sel) wword[8*k +: 8] = wr_sh[8*k +: 8];
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: byte-addressed requests to a word-indexed single-port memory,
// with read-modify-write for sub-word stores.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_lsu_if.slave   pipe,
  dmem_mem_if.master  mem
);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  size_t       size_q, size_d;
  logic        sign_q, sign_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic [31:0] ext_data;
  logic [31:0] merged;

  lsu_align u_align (
    .word     (mem.mem_out),
    .wdata    (wdata_q),
    .offset   (addr_q[1:0]),
    .size     (size_q),
    .sign_ext (sign_q),
    .rdata    (ext_data),
    .wword    (merged)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    sign_d  = sign_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fault_d = fault_q;

    pipe.req_ready  = 1'b0;
    pipe.resp_valid = 1'b0;
    mem.mem_en      = 1'b0;
    mem.mem_r_w     = 1'b0;
    mem.mem_address = '0;
    mem.mem_in      = '0;

    case (state_q)
      IDLE: begin
        pipe.req_ready = 1'b1;
        if (pipe.req_valid) begin
          addr_d  = pipe.req_addr;
          size_d  = size_t'(pipe.req_size);
          sign_d  = pipe.req_signed;
          we_d    = pipe.req_we;
          wdata_d = pipe.req_wdata;
          if (req_fault(pipe.req_size, pipe.req_addr, 32'(DEPTH))) begin
            rdata_d = '0;
            fault_d = 1'b1;
            state_d = RESP;
          end else if (pipe.req_we && (pipe.req_size == WORD)) begin
            state_d = WR;
          end else begin
            state_d = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: begin
        mem.mem_en      = 1'b1;
        mem.mem_address = {2'b00, addr_q[31:2]};
        state_d         = RD_WAIT;
      end
      RD_WAIT: begin
        // wdata_q is reused to hold the merged word for the following write.
        if (we_q) begin
          wdata_d = merged;
          state_d = WR;
        end else begin
          rdata_d = ext_data;
          fault_d = 1'b0;
          state_d = RESP;
        end
      end
      WR: begin
        mem.mem_en      = 1'b1;
        mem.mem_r_w     = 1'b1;
        mem.mem_address = {2'b00, addr_q[31:2]};
        mem.mem_in      = wdata_q;
        rdata_d         = '0;
        fault_d         = 1'b0;
        state_d         = RESP;
      end
      RESP: begin
        pipe.resp_valid = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= BYTE;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign pipe.resp_rdata = rdata_q;
  assign pipe.resp_fault = fault_q;

endmodule
